// File: rtl/multicycle_decoder.sv
// multicycle_decoder: control FSM and ALU decoder for a multicycle ARM-subset processor
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, returns the FSM to FETCH
//   Op         instruction [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
//   Funct      instruction [25:20]: [5]=I, [4:1]=cmd, [0]=S or L
//   Rd         destination register field, instruction [15:12]
//   PCS        PC-write request: (Rd==15 and RegW) or Branch
//   NextPC     unconditional PC update during FETCH
//   RegW MemW IRWrite Branch AdrSrc ALUSrcA  single-bit datapath controls
//   ALUSrcB ResultSrc ImmSrc RegSrc ALUControl FlagW  two-bit datapath controls
//   State      current FSM encoding, exposed for debug
module multicycle_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic [3:0] State
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  logic [3:0] state, next_state;
  logic       alu_op, main_reg_w, legal, is_cmp;
  logic [3:0] cmd;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= next_state;
  // Only DECODE and MEMADR look at the instruction; every other state has a fixed successor.
  always_comb begin
    case (state)
      FETCH:        next_state = DECODE;
      DECODE:       next_state = Op == 2'b01 ? MEMADR :
                                 Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                                 Op == 2'b10 ? BRANCH : FETCH;
      MEMADR:       next_state = Funct[0] ? MEMRD : MEMWR;
      MEMRD:        next_state = MEMWB;
      EXECR, EXECI: next_state = ALUWB;
      default:      next_state = FETCH;
    endcase
  end
  always_comb begin
    NextPC     = 1'b0;
    IRWrite    = 1'b0;
    main_reg_w = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    alu_op     = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc  = 2'b01;
        main_reg_w = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: main_reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end
  assign cmd    = Funct[4:1];
  assign is_cmp = cmd == 4'b1010;
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: ALUControl = 2'b00;
      endcase
      // NZ follow S; C/V only make sense for arithmetic (ADD/SUB) results. CMP always sets all flags.
      FlagW = is_cmp ? 2'b11 : {Funct[0], Funct[0] & ~ALUControl[1]};
    end
  end
  // CMP only updates flags, so its writeback must not touch the register file.
  assign RegW   = main_reg_w & ~(state == ALUWB & is_cmp);
  assign PCS    = (Rd == 4'b1111 & RegW) | Branch;
  assign legal  = state <= BRANCH;
  assign ImmSrc = legal ? Op : 2'b00;
  assign RegSrc = legal ? {Op == 2'b01, Op == 2'b10} : 2'b00;
  assign State  = state;
endmodule

// File: tb/tb_multicycle_decoder.sv
// tb_multicycle_decoder: directed, model-checked bench for multicycle_decoder
module tb_multicycle_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, NextPC, RegW, MemW, IRWrite, Branch, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0] State;
  logic [19:0] act;
  int errors = 0;
  int checks = 0;
  int m_state = 0;
  int path[$];

  multicycle_decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .Branch(Branch), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .State(State)
  );

  always #5 clk = ~clk;

  assign act = {PCS, NextPC, RegW, MemW, IRWrite, Branch, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW};

  function automatic logic [19:0] exp_out(int st, logic [1:0] op, logic [5:0] f, logic [3:0] rd);
    logic pcs, npc, rw, mw, irw, br, adr, asa, aluop, cmp;
    logic [1:0] asb, rs, imm, rsrc, ac, fw;
    logic [3:0] cmd;
    cmd   = f[4:1];
    cmp   = cmd == 4'b1010;
    npc   = st == 0;
    irw   = st == 0;
    asa   = st <= 1;
    asb   = st <= 1 ? 2'd2 : (st == 2 || st == 7 || st == 9) ? 2'd1 : 2'd0;
    rs    = (st <= 1 || st == 9) ? 2'd2 : st == 4 ? 2'd1 : 2'd0;
    adr   = st == 3 || st == 5;
    mw    = st == 5;
    br    = st == 9;
    aluop = st == 6 || st == 7;
    ac    = !aluop ? 2'd0 : cmd == 4'b0100 ? 2'd0 : cmd == 4'b0010 ? 2'd1 :
            cmd == 4'b0000 ? 2'd2 : cmd == 4'b1100 ? 2'd3 : cmp ? 2'd1 : 2'd0;
    fw    = !aluop ? 2'd0 : cmp ? 2'd3 : {f[0], f[0] && (ac == 2'd0 || ac == 2'd1)};
    rw    = st == 4 || (st == 8 && !cmp);
    pcs   = (rd == 4'd15 && rw) || br;
    imm   = st <= 9 ? op : 2'd0;
    rsrc  = st <= 9 ? {op == 2'b01, op == 2'b10} : 2'd0;
    return {pcs, npc, rw, mw, irw, br, adr, asa, asb, rs, imm, rsrc, ac, fw};
  endfunction

  // Instruction-level model: the class chosen in DECODE (and the L bit in MEMADR)
  // queues the remaining steps; an empty queue means the instruction is over.
  task automatic model_step();
    if (!reset) begin
      m_state = 0;
      path.delete();
      return;
    end
    if (m_state == 0) begin
      path.delete();
      path.push_back(1);
    end else if (m_state == 1) begin
      if (Op == 2'b00) begin
        path.push_back(Funct[5] ? 7 : 6);
        path.push_back(8);
      end else if (Op == 2'b01) path.push_back(2);
      else if (Op == 2'b10) path.push_back(9);
    end else if (m_state == 2) begin
      if (Funct[0]) begin
        path.push_back(3);
        path.push_back(4);
      end else path.push_back(5);
    end
    m_state = path.size() > 0 ? path.pop_front() : 0;
  endtask

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("state", 32'(State), 32'(m_state));
    chk("outputs", 32'(act), 32'(exp_out(m_state, Op, Funct, Rd)));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set(logic [1:0] o, logic [5:0] f, logic [3:0] r);
    Op = o;
    Funct = f;
    Rd = r;
  endtask

  initial begin
    reset = 1'b0;
    set(2'b01, 6'b011001, 4'd0);
    #2;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_irwrite", 32'(IRWrite), 32'd1);
    ticks(2);
    reset = 1'b1;
    // LDR
    ticks(4);
    chk("ldr_memwb_state", 32'(State), 32'd4);
    chk("ldr_regw", 32'(RegW), 32'd1);
    chk("ldr_resultsrc", 32'(ResultSrc), 32'd1);
    ticks(1);
    chk("ldr_done", 32'(State), 32'd0);
    // STR
    set(2'b01, 6'b011000, 4'd0);
    ticks(3);
    chk("str_memwr_state", 32'(State), 32'd5);
    chk("str_memw", 32'(MemW), 32'd1);
    chk("str_adrsrc", 32'(AdrSrc), 32'd1);
    ticks(1);
    // ADDS reg, Rd=3
    set(2'b00, 6'b001001, 4'd3);
    ticks(2);
    chk("adds_state", 32'(State), 32'd6);
    chk("adds_aluctl", 32'(ALUControl), 32'd0);
    chk("adds_flagw", 32'(FlagW), 32'd3);
    chk("adds_pcs", 32'(PCS), 32'd0);
    ticks(2);
    // CMP imm
    set(2'b00, 6'b110101, 4'd0);
    ticks(2);
    chk("cmp_state", 32'(State), 32'd7);
    chk("cmp_aluctl", 32'(ALUControl), 32'd1);
    chk("cmp_flagw", 32'(FlagW), 32'd3);
    ticks(1);
    chk("cmp_aluwb_state", 32'(State), 32'd8);
    chk("cmp_regw", 32'(RegW), 32'd0);
    ticks(1);
    // B, then undefined Op
    set(2'b10, 6'b000000, 4'd0);
    ticks(2);
    chk("b_state", 32'(State), 32'd9);
    chk("b_branch", 32'(Branch), 32'd1);
    chk("b_pcs", 32'(PCS), 32'd1);
    ticks(1);
    chk("b_done", 32'(State), 32'd0);
    set(2'b11, 6'b000000, 4'd0);
    ticks(1);
    chk("undef_decode", 32'(State), 32'd1);
    ticks(1);
    chk("undef_fetch", 32'(State), 32'd0);
    // ORR reg, Rd=15
    set(2'b00, 6'b011000, 4'd15);
    ticks(3);
    chk("orr_aluwb", 32'(State), 32'd8);
    chk("orr_pcs", 32'(PCS), 32'd1);
    ticks(1);
    // More ALU patterns: SUB imm no S, ANDS reg, ORRS reg, unknown cmd with S
    set(2'b00, 6'b100100, 4'd1);
    ticks(4);
    set(2'b00, 6'b000001, 4'd2);
    ticks(2);
    chk("ands_flagw", 32'(FlagW), 32'd2);
    chk("ands_aluctl", 32'(ALUControl), 32'd2);
    ticks(2);
    set(2'b00, 6'b011001, 4'd4);
    ticks(4);
    set(2'b00, 6'b000011, 4'd5);
    ticks(4);
    // Inputs changing after DECODE affect outputs but not the path
    set(2'b00, 6'b001000, 4'd1);
    ticks(2);
    set(2'b01, 6'b010100, 4'd15);
    ticks(1);
    chk("midchg_state", 32'(State), 32'd8);
    chk("midchg_immsrc", 32'(ImmSrc), 32'd1);
    chk("midchg_regw_cmp", 32'(RegW), 32'd0);
    ticks(1);
    // Asynchronous reset in MEMRD
    set(2'b01, 6'b011001, 4'd0);
    ticks(3);
    chk("memrd_state", 32'(State), 32'd3);
    #2 reset = 1'b0;
    m_state = 0;
    path.delete();
    #1;
    chk("async_state", 32'(State), 32'd0);
    chk("async_irwrite", 32'(IRWrite), 32'd1);
    chk("async_outputs", 32'(act), 32'(exp_out(0, Op, Funct, Rd)));
    ticks(1);
    reset = 1'b1;
    ticks(1);
    chk("post_reset_decode", 32'(State), 32'd1);
    ticks(4);
    chk("post_reset_done", 32'(State), 32'd0);
    // Illegal encoding
    force dut.state = 4'd12;
    #1;
    chk("illegal_state", 32'(State), 32'd12);
    chk("illegal_outputs", 32'(act), 32'd0);
    release dut.state;
    @(posedge clk);
    #1;
    chk("illegal_recover", 32'(State), 32'd0);
    @(negedge clk);
    ticks(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_decoder.md
MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces state to FETCH immediately, independent of clk.
REQ-003 Op  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-004 Funct  input  6  instruction bits [25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) or L (memory).
REQ-005 Rd  input  4  destination register field, bits [15:12].
REQ-006 outputs, all combinational from state and inputs: PCS 1, NextPC 1, RegW 1, MemW 1, IRWrite 1, Branch 1, AdrSrc 1, ALUSrcA 1, ALUSrcB 2, ResultSrc 2, ImmSrc 2, RegSrc 2, ALUControl 2, FlagW 2.
REQ-007 State  output  4  current state encoding, for debug and bench.

Function
REQ-008 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-009 Transitions SHALL be: FETCH->DECODE; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-010 DECODE SHALL go to MEMADR on Op=01; EXECR on Op=00,Funct[5]=0; EXECI on Op=00,Funct[5]=1; BRANCH on Op=10; FETCH on Op=11.
REQ-011 MEMADR SHALL go to MEMRD when Funct[0]=1, else MEMWR.
REQ-012 Encodings 10-15 SHALL transition to FETCH on the next edge, with all outputs 0.
REQ-013 Per-state outputs (unlisted = 0), ALUOp internal:
 - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
 - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
 - MEMADR: ALUSrcB=01.
 - MEMRD: AdrSrc=1.
 - MEMWB: ResultSrc=01, RegW=1.
 - MEMWR: AdrSrc=1, MemW=1.
 - EXECR: ALUOp=1.
 - EXECI: ALUSrcB=01, ALUOp=1.
 - ALUWB: RegW=1.
 - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-014 ALUOp=0 SHALL give ALUControl=00 and FlagW=00.
REQ-015 ALUOp=1 SHALL map Funct[4:1]: 0100->00 (ADD), 0010->01 (SUB), 0000->10 (AND), 1100->11 (ORR), 1010->01 (CMP); any other cmd->00.
REQ-016 With ALUOp=1, FlagW[1] SHALL be Funct[0], and FlagW[0] SHALL be Funct[0] AND ALUControl in {00,01}; CMP forces FlagW=11 regardless of Funct[0].
REQ-017 CMP in ALUWB SHALL drive RegW=0.
REQ-018 PCS SHALL be (Rd=1111 AND RegW) OR Branch, evaluated every cycle.
REQ-019 ImmSrc SHALL equal Op.
REQ-020 RegSrc[0] SHALL be 1 iff Op=10.
REQ-021 RegSrc[1] SHALL be 1 iff Op=01.
REQ-022 NextPC SHALL NOT be conditioned by any downstream CondEx; PCS, RegW, MemW, FlagW and Branch are conditioned downstream.
REQ-023 Inputs changing mid-instruction SHALL affect outputs combinationally but SHALL alter transitions only in DECODE and MEMADR.

Reset
REQ-024 While reset=0, State SHALL be 0 and outputs SHALL equal the FETCH values.
REQ-025 Reset asserted in any state, including mid-instruction, SHALL abort the instruction; the first rising edge after release SHALL move FETCH->DECODE.

Verification
REQ-026 LDR (Op=01, Funct=011001): states 0,1,2,3,4,0; RegW=1 only in MEMWB; ResultSrc=01 there.
REQ-027 STR (Op=01, Funct=011000): states 0,1,2,5,0; MemW=1 only in MEMWR; AdrSrc=1.
REQ-028 ADDS reg (Op=00, Funct=001001, Rd=0011): 0,1,6,8,0; in EXECR ALUControl=00, FlagW=11; PCS=0 throughout.
REQ-029 CMP imm (Op=00, Funct=110101): 0,1,7,8,0; in EXECI ALUControl=01, FlagW=11; RegW=0 in ALUWB.
REQ-030 B (Op=10) then Op=11: 0,1,9,0 with Branch=PCS=1 in BRANCH; then 0,1,0. ORR with Rd=1111 gives PCS=1 in ALUWB.
REQ-031 reset=0 asserted asynchronously in MEMRD: State=0 before the next edge, IRWrite=1; force State to 12 via bench: all outputs 0, then State=0 on the next edge.
